// File: rtl/u110_pci_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// u110_pci_bus_arbiter_if : request/grant and bus-ownership signals of the arbiter
// Rev 1.0
// ============================================================================
interface u110_pci_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] REQn;
  logic                   FRAMEn;
  logic                   IRDYn;
  logic                   BBn;
  logic                   TSn;
  logic                   LOCKn;
  logic                   BGn;
  logic [NUM_MASTERS-1:0] GNTn;
  logic                   BUSDIR;
  logic [2:0]             PCI_OWNER;

  modport master (
    input  REQn, FRAMEn, IRDYn, BBn, TSn, LOCKn,
    output BGn, GNTn, BUSDIR, PCI_OWNER
  );

  modport slave (
    output REQn, FRAMEn, IRDYn, BBn, TSn, LOCKn,
    input  BGn, GNTn, BUSDIR, PCI_OWNER
  );
endinterface
`default_nettype wire

// File: rtl/u110_pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// u110_pci_bus_arbiter : round-robin arbiter sharing the local bus between the
// 68040 (default owner) and the PCI masters. Optional macro ARB_TENURE_LIMIT_EN.
// Rev 1.0
// ============================================================================
module u110_pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int MAX_TENURE  = 64
) (
  input  wire logic              CLK40,
  input  wire logic              RESETn,
  u110_pci_bus_arbiter_if.master bus
);

  localparam int CNT_W = $clog2((GNT_TIMEOUT > MAX_TENURE) ? GNT_TIMEOUT : MAX_TENURE) + 1;

  typedef enum logic [2:0] {
    CPU_OWN     = 3'd0,
    CPU_RELEASE = 3'd1,
    PCI_GRANT   = 3'd2,
    PCI_OWN     = 3'd3,
    PCI_DRAIN   = 3'd4,
    TURNAROUND  = 3'd5
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_req_s1, r_req_s2;
  logic                   r_frame_s1, r_frame_s2;
  logic                   r_irdy_s1, r_irdy_s2;
  logic                   r_bgn, w_bgn_nxt;
  logic [NUM_MASTERS-1:0] r_gntn, w_gntn_nxt;
  logic                   r_busdir, w_busdir_nxt;
  logic [2:0]             r_owner, w_owner_nxt;
  logic [2:0]             r_winner, w_winner_nxt;
  logic [2:0]             r_rr, w_rr_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;

  logic [NUM_MASTERS-1:0] w_req_act;
  logic [7:0]             w_req8;
  logic [NUM_MASTERS-1:0] w_grant_n;
  logic [2:0]             w_pick;
  logic [2:0]             w_idx;
  logic                   w_found;
  logic                   w_win_req;

  assign w_req_act = ~r_req_s2;
  assign w_req8    = 8'(w_req_act);
  assign w_win_req = w_req8[r_winner];

  // Round-robin search starting at the pointer, wrapping through index 0
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_idx = 3'((int'(r_rr) + k) % NUM_MASTERS);
      if (!w_found && w_req8[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant_n = '1;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_grant_n[m] = (3'(m) != r_winner);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bgn_nxt    = r_bgn;
    w_gntn_nxt   = r_gntn;
    w_busdir_nxt = r_busdir;
    w_owner_nxt  = r_owner;
    w_winner_nxt = r_winner;
    w_rr_nxt     = r_rr;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      CPU_OWN: begin
        if (w_found && bus.LOCKn) begin
          w_winner_nxt = w_pick;
          w_bgn_nxt    = 1'b1;
          w_state_nxt  = CPU_RELEASE;
        end
      end
      CPU_RELEASE: begin
        // A withdrawn request takes priority so an idle master is never granted
        if (!w_win_req) begin
          w_bgn_nxt   = 1'b0;
          w_state_nxt = CPU_OWN;
        end else if (bus.BBn && bus.TSn) begin
          w_gntn_nxt   = w_grant_n;
          w_busdir_nxt = 1'b1;
          w_owner_nxt  = r_winner;
          w_cnt_nxt    = '0;
          w_state_nxt  = PCI_GRANT;
        end
      end
      PCI_GRANT: begin
        if (!r_frame_s2) begin
          w_cnt_nxt   = '0;
          w_state_nxt = PCI_OWN;
        end else if ((r_cnt == CNT_W'(GNT_TIMEOUT - 1)) || !w_win_req) begin
          w_gntn_nxt   = '1;
          w_busdir_nxt = 1'b0;
          w_state_nxt  = TURNAROUND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PCI_OWN: begin
        if (!w_win_req) begin
          w_gntn_nxt  = '1;
          w_state_nxt = PCI_DRAIN;
        end
`ifdef ARB_TENURE_LIMIT_EN
        else if (r_cnt == CNT_W'(MAX_TENURE - 1)) begin
          w_gntn_nxt  = '1;
          w_state_nxt = PCI_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`else
        else begin
          w_cnt_nxt = r_cnt;
        end
`endif
      end
      PCI_DRAIN: begin
        // BUSDIR drops as the bus goes idle so it is low throughout TURNAROUND
        if (r_frame_s2 && r_irdy_s2) begin
          w_busdir_nxt = 1'b0;
          w_state_nxt  = TURNAROUND;
        end
      end
      TURNAROUND: begin
        w_busdir_nxt = 1'b0;
        w_rr_nxt     = (r_winner >= 3'(NUM_MASTERS - 1)) ? 3'd0 : (r_winner + 3'd1);
        w_bgn_nxt    = 1'b0;
        w_state_nxt  = CPU_OWN;
      end
      default: begin
        w_state_nxt  = CPU_OWN;
        w_bgn_nxt    = 1'b0;
        w_gntn_nxt   = '1;
        w_busdir_nxt = 1'b0;
        w_owner_nxt  = '0;
        w_winner_nxt = '0;
        w_rr_nxt     = '0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      r_req_s1   <= '1;
      r_req_s2   <= '1;
      r_frame_s1 <= 1'b1;
      r_frame_s2 <= 1'b1;
      r_irdy_s1  <= 1'b1;
      r_irdy_s2  <= 1'b1;
      r_state    <= CPU_OWN;
      r_bgn      <= 1'b0;
      r_gntn     <= '1;
      r_busdir   <= 1'b0;
      r_owner    <= '0;
      r_winner   <= '0;
      r_rr       <= '0;
      r_cnt      <= '0;
    end else begin
      r_req_s1   <= bus.REQn;
      r_req_s2   <= r_req_s1;
      r_frame_s1 <= bus.FRAMEn;
      r_frame_s2 <= r_frame_s1;
      r_irdy_s1  <= bus.IRDYn;
      r_irdy_s2  <= r_irdy_s1;
      r_state    <= w_state_nxt;
      r_bgn      <= w_bgn_nxt;
      r_gntn     <= w_gntn_nxt;
      r_busdir   <= w_busdir_nxt;
      r_owner    <= w_owner_nxt;
      r_winner   <= w_winner_nxt;
      r_rr       <= w_rr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.BGn       = r_bgn;
  assign bus.GNTn      = r_gntn;
  assign bus.BUSDIR    = r_busdir;
  assign bus.PCI_OWNER = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_u110_pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_u110_pci_bus_arbiter : directed bench for the PCI/68040 bus arbiter
// Rev 1.0
// ============================================================================
module tb_u110_pci_bus_arbiter;

  localparam int NM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt;
  logic saw_low;
  logic [3:0] exp_gnt [4];

  always #12 clk = ~clk;

  u110_pci_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  u110_pci_bus_arbiter #(
    .NUM_MASTERS(NM),
    .GNT_TIMEOUT(16),
    .MAX_TENURE (64)
  ) dut (
    .CLK40 (clk),
    .RESETn(rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.REQn   = '1;
    bus.FRAMEn = 1'b1;
    bus.IRDYn  = 1'b1;
    bus.BBn    = 1'b1;
    bus.TSn    = 1'b1;
    bus.LOCKn  = 1'b1;
    rst_n      = 1'b0;
    tick(3);
    rst_n      = 1'b1;
    tick(1);
  endtask

  task automatic wait_bgn_low(input string tag, input int lim);
    int k = 0;
    while (bus.BGn !== 1'b0 && k < lim) begin
      tick(1);
      k++;
    end
    chk(tag, bus.BGn, 1'b0);
  endtask

  task automatic wait_grant(input string tag, input int lim);
    int k = 0;
    while (bus.GNTn === 4'hF && k < lim) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(bus.GNTn !== 4'hF), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_gnt[0] = 4'b1110;
    exp_gnt[1] = 4'b1101;
    exp_gnt[2] = 4'b1011;
    exp_gnt[3] = 4'b0111;

    // Reset state held while idle
    bus.REQn = '1; bus.FRAMEn = 1'b1; bus.IRDYn = 1'b1;
    bus.BBn = 1'b1; bus.TSn = 1'b1; bus.LOCKn = 1'b1;
    rst_n = 1'b0;
    tick(2);
    chk("rst_bgn", bus.BGn, 1'b0);
    chk("rst_gnt", bus.GNTn, 4'hF);
    chk("rst_busdir", bus.BUSDIR, 1'b0);
    chk("rst_owner", bus.PCI_OWNER, 3'd0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_bgn", bus.BGn, 1'b0);
    chk("idle_gnt", bus.GNTn, 4'hF);
    chk("idle_busdir", bus.BUSDIR, 1'b0);

    // Single tenure by master 2
    bus.REQn = 4'b1011;
    tick(2);
    chk("m2_bgn_sync", bus.BGn, 1'b0);
    tick(1);
    chk("m2_bgn", bus.BGn, 1'b1);
    chk("m2_gnt_pre", bus.GNTn, 4'hF);
    tick(1);
    chk("m2_gnt", bus.GNTn, 4'b1011);
    chk("m2_busdir", bus.BUSDIR, 1'b1);
    chk("m2_owner", bus.PCI_OWNER, 3'd2);
    tick(6);
    bus.FRAMEn = 1'b0;
    tick(20);
    chk("m2_hold", bus.GNTn, 4'b1011);
    bus.REQn = 4'hF;
    tick(3);
    chk("m2_rel_gnt", bus.GNTn, 4'hF);
    tick(1);
    chk("m2_drain_busdir", bus.BUSDIR, 1'b1);
    bus.FRAMEn = 1'b1;
    wait_bgn_low("m2_ret_bgn", 10);
    chk("m2_ret_busdir", bus.BUSDIR, 1'b0);
    chk("m2_ret_owner", bus.PCI_OWNER, 3'd2);
    chk("m2_ret_gnt", bus.GNTn, 4'hF);

    // CPU keeps the bus busy, request withdrawn before grant
    tick(3);
    bus.BBn  = 1'b0;
    bus.REQn = 4'b1110;
    tick(3);
    chk("busy_bgn", bus.BGn, 1'b1);
    tick(4);
    chk("busy_nogrant", bus.GNTn, 4'hF);
    bus.REQn = 4'hF;
    tick(2);
    chk("busy_bgn_hold", bus.BGn, 1'b1);
    tick(1);
    chk("busy_withdraw", bus.BGn, 1'b0);
    chk("busy_withdraw_gnt", bus.GNTn, 4'hF);
    bus.BBn = 1'b1;
    tick(3);
    chk("busy_idle", bus.BGn, 1'b0);

    // Round robin over all four masters, each timing out
    do_reset();
    bus.REQn = 4'b0000;
    wait_grant("rr_first", 10);
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt", bus.GNTn, exp_gnt[i]);
      chk("rr_owner", bus.PCI_OWNER, 3'(i));
      cnt = 0;
      while (bus.GNTn !== 4'hF && cnt < 30) begin
        tick(1);
        cnt++;
      end
      chk("rr_release", bus.GNTn, 4'hF);
      saw_low = 1'b0;
      cnt = 0;
      while (bus.GNTn === 4'hF && cnt < 10) begin
        if (bus.BGn === 1'b0) saw_low = 1'b1;
        tick(1);
        cnt++;
      end
      chk("rr_gap_bgn_low", saw_low, 1'b1);
    end
    chk("rr_wrap", bus.GNTn, 4'b1110);

    // Asynchronous reset in the middle of a tenure
    rst_n = 1'b0;
    #2;
    chk("midrst_gnt", bus.GNTn, 4'hF);
    chk("midrst_bgn", bus.BGn, 1'b0);
    chk("midrst_busdir", bus.BUSDIR, 1'b0);
    chk("midrst_owner", bus.PCI_OWNER, 3'd0);

    // Grant timeout with FRAMEn never asserted
    do_reset();
    bus.REQn = 4'b1101;
    wait_grant("to_grant", 10);
    chk("to_gnt", bus.GNTn, 4'b1101);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (bus.GNTn !== 4'b1101) break;
      cnt++;
    end
    chk("to_len", cnt, 16);
    chk("to_gnt_rel", bus.GNTn, 4'hF);
    chk("to_bgn_hold", bus.BGn, 1'b1);
    wait_bgn_low("to_bgn_ret", 2);
    bus.REQn = 4'hF;

    // LOCKn blocks arbitration away from the CPU
    do_reset();
    bus.LOCKn = 1'b0;
    bus.REQn  = 4'b1110;
    tick(8);
    chk("lock_bgn", bus.BGn, 1'b0);
    chk("lock_gnt", bus.GNTn, 4'hF);
    bus.LOCKn = 1'b1;
    tick(1);
    chk("lock_rel_bgn", bus.BGn, 1'b1);
    tick(1);
    chk("lock_gnt_m0", bus.GNTn, 4'b1110);

    // FRAMEn and withdrawal in the same grant cycle: FRAMEn wins
    bus.REQn   = 4'hF;
    bus.FRAMEn = 1'b0;
    tick(4);
    chk("simul_gnt", bus.GNTn, 4'hF);
    tick(6);
    chk("simul_drain_busdir", bus.BUSDIR, 1'b1);
    bus.FRAMEn = 1'b1;
    wait_bgn_low("simul_ret", 10);
    chk("simul_ret_busdir", bus.BUSDIR, 1'b0);

`ifdef ARB_TENURE_LIMIT_EN
    // Tenure limit forces master 3 off the bus, then master 0 is served
    do_reset();
    bus.REQn = 4'b0111;
    wait_grant("ten_grant", 10);
    chk("ten_gnt", bus.GNTn, 4'b0111);
    bus.FRAMEn = 1'b0;
    cnt = 1;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      bus.IRDYn = ~bus.IRDYn;
      if (bus.GNTn !== 4'b0111) break;
      cnt++;
    end
    chk("ten_len", cnt, 67);
    bus.REQn   = 4'b0110;
    bus.FRAMEn = 1'b1;
    bus.IRDYn  = 1'b1;
    wait_bgn_low("ten_bgn_ret", 10);
    wait_grant("ten_next", 10);
    chk("ten_next_m0", bus.GNTn, 4'b1110);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
